axis_packet_source: RTL and testbench

Programmable AXI-Stream packet generator that sits directly upstream of the AXIS slave receive stage. It replaces the bench's hand-driven DMA master with a synthesizable source. On a start command it emits one packet of `pkt_len` beats with incrementing data and a full TKEEP. It marks the final beat with TLAST, honours TREADY backpressure, and reports completion. It is used both in simulation loops (source → AXIS slave → FIFO → AXIS master) and as an on-chip traffic generator.

---
 rtl/axis_packet_source.sv | 151 +++++++++++++++
 tb/tb_axis_packet_source.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_source.sv
// AXI-Stream packet generator: emits pkt_len beats of incrementing data with full TKEEP and TLAST.
// Optional inter-beat gap support is compiled in with `define AXIS_SRC_GAP_EN.
module axis_packet_source #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int LEN_WIDTH            = 16,
  parameter int GAP_WIDTH            = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [LEN_WIDTH-1:0]              pkt_len,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   first_data,
`ifdef AXIS_SRC_GAP_EN
  input  logic [GAP_WIDTH-1:0]              gap_cycles,
`endif
  output logic                              busy,
  output logic                              done,
  output logic [LEN_WIDTH-1:0]              beat_count,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  input  logic                              M_AXIS_TREADY,
  output logic                              M_AXIS_TLAST
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
`ifdef AXIS_SRC_GAP_EN
    S_GAP  = 2'd3,
`endif
    S_DONE = 2'd2
  } state_t;

  state_t                            state_q, state_d;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]   data_q, data_d;
  logic [LEN_WIDTH-1:0]              remain_q, remain_d;
  logic [LEN_WIDTH-1:0]              beat_count_q, beat_count_d;
`ifdef AXIS_SRC_GAP_EN
  logic [GAP_WIDTH-1:0]              gap_len_q, gap_len_d;
  logic [GAP_WIDTH-1:0]              gap_cnt_q, gap_cnt_d;
`endif

  logic valid;
  logic handshake;
  logic last_beat;

  // All stream outputs decode from registered state only, so TVALID never sees TREADY.
  assign valid     = (state_q == S_SEND);
  assign last_beat = (remain_q == LEN_WIDTH'(1));
  assign handshake = valid & M_AXIS_TREADY;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      data_q       <= '0;
      remain_q     <= '0;
      beat_count_q <= '0;
`ifdef AXIS_SRC_GAP_EN
      gap_len_q    <= '0;
      gap_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      remain_q     <= remain_d;
      beat_count_q <= beat_count_d;
`ifdef AXIS_SRC_GAP_EN
      gap_len_q    <= gap_len_d;
      gap_cnt_q    <= gap_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    remain_d     = remain_q;
    beat_count_d = beat_count_q;
`ifdef AXIS_SRC_GAP_EN
    gap_len_d    = gap_len_q;
    gap_cnt_d    = gap_cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          beat_count_d = '0;
          if (pkt_len != '0) begin
            state_d  = S_SEND;
            data_d   = first_data;
            remain_d = pkt_len;
`ifdef AXIS_SRC_GAP_EN
            gap_len_d = gap_cycles;
`endif
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_SEND: begin
        if (handshake) begin
          data_d   = data_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (beat_count_q != '1) begin
            beat_count_d = beat_count_q + 1'b1;
          end
          if (last_beat) begin
            state_d = S_DONE;
`ifdef AXIS_SRC_GAP_EN
          end else if (gap_len_q != '0) begin
            state_d   = S_GAP;
            gap_cnt_d = gap_len_q;
`endif
          end
        end
      end

`ifdef AXIS_SRC_GAP_EN
      // Counter is loaded with G and the state exits when it reads 1, giving G idle cycles.
      S_GAP: begin
        if (gap_cnt_q <= GAP_WIDTH'(1)) begin
          state_d = S_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    M_AXIS_TVALID = valid;
    M_AXIS_TDATA  = data_q;
    M_AXIS_TKEEP  = valid ? '1 : '0;
    M_AXIS_TLAST  = valid & last_beat;
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    beat_count    = beat_count_q;
  end

endmodule

// File: tb/tb_axis_packet_source.sv
// Scoreboard bench for axis_packet_source: expected beats queued at start, checked on handshake.
`timescale 1ns/1ps
module tb_axis_packet_source;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] pkt_len = '0;
  logic [31:0] first_data = '0;
`ifdef AXIS_SRC_GAP_EN
  logic [3:0]  gap_cycles = '0;
`endif
  logic        busy, done;
  logic [15:0] beat_count;
  logic        M_AXIS_TVALID;
  logic [31:0] M_AXIS_TDATA;
  logic [3:0]  M_AXIS_TKEEP;
  logic        M_AXIS_TREADY = 1'b1;
  logic        M_AXIS_TLAST;

  int tests = 0;
  int fails = 0;

  beat_t exp_q[$];
  int    hs_cyc_q[$];
  int    cyc = 0;
  int    hs_cnt = 0;
  int    valid_cnt = 0;
  int    done_cnt = 0;
  int    done_cyc = 0;
  int    last_hs_cyc = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  axis_packet_source #(
    .C_M_AXIS_TDATA_WIDTH(32),
    .LEN_WIDTH(16),
    .GAP_WIDTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .pkt_len(pkt_len),
    .first_data(first_data),
`ifdef AXIS_SRC_GAP_EN
    .gap_cycles(gap_cycles),
`endif
    .busy(busy),
    .done(done),
    .beat_count(beat_count),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TDATA(M_AXIS_TDATA),
    .M_AXIS_TKEEP(M_AXIS_TKEEP),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TLAST(M_AXIS_TLAST)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stream monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      tests++;
      if (M_AXIS_TKEEP !== (M_AXIS_TVALID ? 4'hF : 4'h0)) begin
        fails++;
        $display("FAIL tkeep: got %h with tvalid=%b", M_AXIS_TKEEP, M_AXIS_TVALID);
      end
      if (prev_stall) begin
        tests++;
        if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== prev_data || M_AXIS_TLAST !== prev_last) begin
          fails++;
          $display("FAIL stall_stable: got v=%b d=%h l=%b, need v=1 d=%h l=%b",
                   M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, prev_data, prev_last);
        end
      end
      if (M_AXIS_TVALID === 1'b1) valid_cnt++;
      if (M_AXIS_TVALID === 1'b1 && M_AXIS_TREADY === 1'b1) begin
        hs_cnt++;
        hs_cyc_q.push_back(cyc);
        if (M_AXIS_TLAST === 1'b1) last_hs_cyc = cyc;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat: got data %h, none expected", M_AXIS_TDATA);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (M_AXIS_TDATA !== e.data || M_AXIS_TLAST !== e.last) begin
            fails++;
            $display("FAIL beat: got d=%h l=%b, need d=%h l=%b",
                     M_AXIS_TDATA, M_AXIS_TLAST, e.data, e.last);
          end
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = M_AXIS_TVALID & ~M_AXIS_TREADY;
      prev_data  = M_AXIS_TDATA;
      prev_last  = M_AXIS_TLAST;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_pkt(input logic [15:0] len, input logic [31:0] first);
    beat_t b;
    for (int i = 0; i < int'(len); i++) begin
      b.data = first + 32'(i);
      b.last = (i == int'(len) - 1);
      exp_q.push_back(b);
    end
    @(posedge clk); #1;
    start = 1'b1; pkt_len = len; first_data = first;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) seen = 1'b1;
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL %s_done_timeout: got no done within %0d cycles, need one", name, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, busy, done, beat_count} !== '0) begin
      fails++;
      $display("FAIL reset_values: got v=%b d=%h k=%h l=%b busy=%b done=%b bc=%0d, need all zero",
               M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, busy, done, beat_count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || M_AXIS_TVALID !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b v=%b, need 0 0", busy, M_AXIS_TVALID);
    end
  endtask

  task automatic test_basic();
    M_AXIS_TREADY = 1'b1;
    valid_cnt = 0;
    start_pkt(16'd50, 32'd1);
    @(negedge clk);
    tests++;
    if (M_AXIS_TVALID !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL start_latency: got v=%b busy=%b, need 1 1", M_AXIS_TVALID, busy);
    end
    wait_done(200, "basic");
    tests++;
    if (done_cyc - last_hs_cyc != 1) begin
      fails++;
      $display("FAIL basic_done_timing: got %0d cycles after last beat, need 1", done_cyc - last_hs_cyc);
    end
    tests++;
    if (valid_cnt != 50) begin
      fails++;
      $display("FAIL basic_valid_cycles: got %0d, need 50", valid_cnt);
    end
    tests++;
    if (beat_count !== 16'd50 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL basic_count: got bc=%0d left=%0d, need 50 0", beat_count, exp_q.size());
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_after_done: got done=%b busy=%b, need 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    bit found;
    M_AXIS_TREADY = 1'b1;
    start_pkt(16'd8, 32'h10);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (M_AXIS_TVALID === 1'b1 && M_AXIS_TDATA === 32'h13) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL bp_find_beat3: got no 0x13 beat, need one");
    end
    M_AXIS_TREADY = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    tests++;
    if (M_AXIS_TDATA !== 32'h13 || M_AXIS_TVALID !== 1'b1) begin
      fails++;
      $display("FAIL bp_hold: got v=%b d=%h, need 1 00000013", M_AXIS_TVALID, M_AXIS_TDATA);
    end
    @(posedge clk); #1;
    M_AXIS_TREADY = 1'b1;
    @(posedge clk); #1;
    M_AXIS_TREADY = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    M_AXIS_TREADY = 1'b1;
    wait_done(100, "bp");
    tests++;
    if (beat_count !== 16'd8 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL bp_count: got bc=%0d left=%0d, need 8 0", beat_count, exp_q.size());
    end
  endtask

  task automatic test_edges();
    int first_hs;
    M_AXIS_TREADY = 1'b1;
    start_pkt(16'd1, 32'hFFFF_FFFF);
    wait_done(20, "len1");
    tests++;
    if (beat_count !== 16'd1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL len1_count: got bc=%0d left=%0d, need 1 0", beat_count, exp_q.size());
    end
    hs_cyc_q.delete();
    first_hs = last_hs_cyc;
    start_pkt(16'd2, 32'hFFFF_FFFF);
    wait_done(20, "wrap");
    tests++;
    if (hs_cyc_q.size() != 2 || hs_cyc_q[0] - first_hs != 3) begin
      fails++;
      $display("FAIL back_to_back_gap: got %0d beats, spacing %0d, need 2 beats spacing 3",
               hs_cyc_q.size(), (hs_cyc_q.size() > 0) ? hs_cyc_q[0] - first_hs : -1);
    end
    tests++;
    if (beat_count !== 16'd2 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL wrap_count: got bc=%0d left=%0d, need 2 0", beat_count, exp_q.size());
    end
    valid_cnt = 0;
    start_pkt(16'd0, 32'h1234);
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || M_AXIS_TVALID !== 1'b0 || beat_count !== 16'd0) begin
      fails++;
      $display("FAIL zero_len: got done=%b v=%b bc=%0d, need 1 0 0", done, M_AXIS_TVALID, beat_count);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (valid_cnt != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_len_idle: got valid cycles=%0d busy=%b, need 0 0", valid_cnt, busy);
    end
  endtask

  task automatic test_start_while_busy();
    int d0;
    M_AXIS_TREADY = 1'b1;
    d0 = done_cnt;
    start_pkt(16'd10, 32'h100);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; pkt_len = 16'd3; first_data = 32'hAAA;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(50, "busy_start");
    repeat (6) @(negedge clk);
    tests++;
    if (done_cnt - d0 != 1 || exp_q.size() != 0 || beat_count !== 16'd10) begin
      fails++;
      $display("FAIL start_while_busy: got dones=%0d left=%0d bc=%0d, need 1 0 10",
               done_cnt - d0, exp_q.size(), beat_count);
    end
  endtask

  task automatic test_reset_mid_packet();
    int d0;
    bit reached;
    M_AXIS_TREADY = 1'b1;
    hs_cnt = 0;
    start_pkt(16'd50, 32'h2000);
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      @(negedge clk); #1;
      if (hs_cnt >= 20) reached = 1'b1;
    end
    tests++;
    if (!reached) begin
      fails++;
      $display("FAIL rst_mid_reach: got %0d beats, need 20", hs_cnt);
    end
    @(posedge clk); #2;
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    tests++;
    if (M_AXIS_TVALID !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_async: got v=%b busy=%b, need 0 0", M_AXIS_TVALID, busy);
    end
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (done_cnt != d0 || busy !== 1'b0 || M_AXIS_TVALID !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_idle: got dones=%0d busy=%b v=%b, need 0 0 0",
               done_cnt - d0, busy, M_AXIS_TVALID);
    end
    start_pkt(16'd4, 32'h40);
    wait_done(20, "rst_restart");
    tests++;
    if (beat_count !== 16'd4 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL rst_restart_count: got bc=%0d left=%0d, need 4 0", beat_count, exp_q.size());
    end
  endtask

`ifdef AXIS_SRC_GAP_EN
  task automatic test_gap();
    M_AXIS_TREADY = 1'b1;
    gap_cycles = 4'd3;
    hs_cyc_q.delete();
    start_pkt(16'd4, 32'h500);
    gap_cycles = 4'd0;
    wait_done(60, "gap");
    tests++;
    if (hs_cyc_q.size() != 4) begin
      fails++;
      $display("FAIL gap_beats: got %0d, need 4", hs_cyc_q.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        tests++;
        if (hs_cyc_q[i] - hs_cyc_q[i-1] != 4) begin
          fails++;
          $display("FAIL gap_spacing: got %0d, need 4", hs_cyc_q[i] - hs_cyc_q[i-1]);
        end
      end
    end
    tests++;
    if (done_cyc - last_hs_cyc != 1) begin
      fails++;
      $display("FAIL gap_done_timing: got %0d, need 1", done_cyc - last_hs_cyc);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_edges();
    test_start_while_busy();
    test_reset_mid_packet();
`ifdef AXIS_SRC_GAP_EN
    test_gap();
`endif
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
